gpu_ram_host_port_arbiter: RTL and testbench

//  Round-robin arbiter that shares the host-side port B of the GPU dual-port RAM between NUM_REQ requesters
//  (e.g. Z80 bus interface, blitter, palette loader). Port A remains owned by the pixel pipeline.

---
 rtl/gpu_ram_host_port_arbiter_pkg.sv | 10 +
 rtl/gpu_ram_host_port_arbiter_if.sv | 27 ++
 rtl/gpu_rr_picker.sv | 29 ++
 rtl/gpu_ram_host_port_arbiter.sv | 51 +++++
 tb/tb_gpu_ram_host_port_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_ram_host_port_arbiter_pkg.sv
// gpu_ram_host_port_arbiter_pkg: shared defaults and pointer-advance helper for the port-B arbiter
package gpu_ram_host_port_arbiter_pkg;
  localparam int MAX_REQ = 4;
  localparam int GPU_ADDR_W = 20;
  localparam int GPU_RAM_RD_LATENCY = 2;
  // Round-robin moves past the winner; fixed-priority keeps lane 0 out of the rotation (range 1..n-1)
  function automatic int next_ptr(input int ptr, input int g, input int n, input bit fixed);
    return fixed ? (g == 0 ? ptr : (g + 1 == n ? 1 : g + 1)) : (g + 1) % n;
  endfunction
endpackage

// File: rtl/gpu_ram_host_port_arbiter_if.sv
// gpu_ram_host_port_arbiter_if: requester bundle plus RAM port-B pins of the host-port arbiter
interface gpu_ram_host_port_arbiter_if
  import gpu_ram_host_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = GPU_ADDR_W
);
  logic [NUM_REQ-1:0] req_in;
  logic [NUM_REQ-1:0] wr_in;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ*8-1:0] data_in;
  logic [NUM_REQ-1:0] ack_out;
  logic [NUM_REQ-1:0] rd_valid_out;
  logic [7:0] rd_data_out;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [7:0] ram_data_b;
  logic ram_wr_en_b;
  logic [7:0] ram_q_b;
  modport master (
    output req_in, wr_in, addr_in, data_in, ram_q_b,
    input ack_out, rd_valid_out, rd_data_out, ram_addr_b, ram_data_b, ram_wr_en_b
  );
  modport slave (
    input req_in, wr_in, addr_in, data_in, ram_q_b,
    output ack_out, rd_valid_out, rd_data_out, ram_addr_b, ram_data_b, ram_wr_en_b
  );
endinterface

// File: rtl/gpu_rr_picker.sv
// gpu_rr_picker: combinational one-hot grant search starting at ptr, optional lane-0 priority
module gpu_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int FIXED_PRIO = 0,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  // Descending offset scan so the nearest requester at or after ptr is the last (winning) assignment
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int i;
      i = (int'(ptr) + k) % NUM_REQ;
      if (req[i] && !(FIXED_PRIO != 0 && i == 0)) begin
        grant = NUM_REQ'(1) << i;
        idx = IW'(i);
      end
    end
    if (FIXED_PRIO != 0 && req[0]) begin
      grant = NUM_REQ'(1);
      idx = '0;
    end
  end
endmodule

// File: rtl/gpu_ram_host_port_arbiter.sv
// gpu_ram_host_port_arbiter: shares RAM port B among requesters, one transaction per clock, tagged read returns
module gpu_ram_host_port_arbiter
  import gpu_ram_host_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = GPU_ADDR_W,
  parameter int RD_LATENCY = GPU_RAM_RD_LATENCY,
  parameter int FIXED_PRIO = 0
) (
  input logic clk,
  input logic rst_n,
  gpu_ram_host_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("NUM_REQ out of range");
  end
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [NUM_REQ-1:0] grant;
  logic any;
  logic [RD_LATENCY:0][NUM_REQ-1:0] tags;
  gpu_rr_picker #(.NUM_REQ(NUM_REQ), .FIXED_PRIO(FIXED_PRIO), .IW(IW)) u_picker (
    .req(bus.req_in),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );
  assign any = |bus.req_in;
  assign bus.ack_out = rst_n ? grant : '0;
  assign bus.rd_valid_out = tags[RD_LATENCY];
  assign bus.rd_data_out = bus.ram_q_b;
  // Issue the winner to port B and shift its one-hot read tag toward the return slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      bus.ram_addr_b <= '0;
      bus.ram_data_b <= '0;
      bus.ram_wr_en_b <= 1'b0;
      tags <= '0;
    end else begin
      bus.ram_wr_en_b <= any && bus.wr_in[idx];
      tags <= {tags[RD_LATENCY-1:0], (any && !bus.wr_in[idx]) ? grant : NUM_REQ'(0)};
      if (any) begin
        ptr <= IW'(next_ptr(int'(ptr), int'(idx), NUM_REQ, FIXED_PRIO != 0));
        bus.ram_addr_b <= bus.addr_in[idx*ADDR_W +: ADDR_W];
        bus.ram_data_b <= bus.data_in[idx*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_gpu_ram_host_port_arbiter.sv
// tb_gpu_ram_host_port_arbiter: directed checks of grant order, issue timing and read returns
module tb_gpu_ram_host_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  gpu_ram_host_port_arbiter_if #(.NUM_REQ(3), .ADDR_W(20)) bi ();
  gpu_ram_host_port_arbiter_if #(.NUM_REQ(3), .ADDR_W(20)) bf ();

  gpu_ram_host_port_arbiter #(.NUM_REQ(3), .ADDR_W(20), .RD_LATENCY(2), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bi.slave)
  );
  gpu_ram_host_port_arbiter #(.NUM_REQ(3), .ADDR_W(20), .RD_LATENCY(2), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bf.slave)
  );

  // RAM port-B model: address register then output register, two clocks of read latency
  logic [7:0] mem [4096];
  logic [11:0] ar;
  logic [7:0] q;
  logic pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bi.ram_wr_en_b) mem[bi.ram_addr_b[11:0]] <= bi.ram_data_b;
    ar <= bi.ram_addr_b[11:0];
    q <= mem[ar];
  end
  assign bi.ram_q_b = q;
  assign bf.ram_q_b = 8'h00;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input bit r, input bit w, input logic [19:0] a, input logic [7:0] d);
    bi.req_in[i] = r;
    bi.wr_in[i] = w;
    bi.addr_in[i*20 +: 20] = a;
    bi.data_in[i*8 +: 8] = d;
  endtask

  task automatic idle;
    bi.req_in = '0;
    bi.wr_in = '0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    lane(0, 1'b1, 1'b0, 20'h5, 8'h0);
    #1;
    total++; if (bi.ack_out !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b want=000", bi.ack_out); end
    total++; if (bi.ram_addr_b !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bi.ram_addr_b); end
    total++; if (bi.ram_wr_en_b !== 1'b0 || bi.ram_data_b !== 8'h0) begin bad++; $display("FAIL reset_wr got=%b/%h want=0/00", bi.ram_wr_en_b, bi.ram_data_b); end
    total++; if (bi.rd_valid_out !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b want=000", bi.rd_valid_out); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bi.ack_out !== 3'b001) begin bad++; $display("FAIL reset_first_ack got=%b want=001", bi.ack_out); end
    tick();
    lane(0, 1'b1, 1'b0, 20'h6, 8'h0);
    @(negedge clk);
    total++; if (bi.ram_addr_b !== 20'h5) begin bad++; $display("FAIL reset_issue_addr got=%h want=00005", bi.ram_addr_b); end
    tick();
    lane(0, 1'b1, 1'b0, 20'h7, 8'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bi.ack_out !== 3'b000) begin bad++; $display("FAIL midreset_ack got=%b want=000", bi.ack_out); end
    total++; if (bi.ram_addr_b !== 20'h0) begin bad++; $display("FAIL midreset_addr got=%h want=0", bi.ram_addr_b); end
    tick();
    idle();
    tick();
    rst_n = 1'b1;
    begin
      int pulses = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bi.rd_valid_out !== 3'b000) pulses++;
        tick();
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL reset_discard got=%0d pulses want=0", pulses); end
    end
  endtask

  task automatic test_single_read;
    lane(0, 1'b1, 1'b0, 20'h00123, 8'h0);
    @(negedge clk);
    total++; if (bi.ack_out !== 3'b001) begin bad++; $display("FAIL single_ack got=%b want=001", bi.ack_out); end
    tick();
    idle();
    @(negedge clk);
    total++; if (bi.ram_addr_b !== 20'h00123 || bi.ram_wr_en_b !== 1'b0) begin bad++; $display("FAIL single_issue got=%h/%b want=00123/0", bi.ram_addr_b, bi.ram_wr_en_b); end
    tick();
    @(negedge clk);
    total++; if (bi.rd_valid_out !== 3'b000) begin bad++; $display("FAIL single_early got=%b want=000", bi.rd_valid_out); end
    tick();
    @(negedge clk);
    total++; if (bi.rd_valid_out !== 3'b001 || bi.rd_data_out !== 8'h5A) begin bad++; $display("FAIL single_return got=%b/%h want=001/5a", bi.rd_valid_out, bi.rd_data_out); end
    tick();
  endtask

  task automatic test_contention;
    do_reset();
    lane(0, 1'b1, 1'b0, 20'h10, 8'h0);
    lane(1, 1'b1, 1'b0, 20'h11, 8'h0);
    for (int c = 0; c < 12; c++) begin
      logic [2:0] ea, ev;
      if (c == 8) idle();
      ea = c < 8 ? (c % 2 == 1 ? 3'b010 : 3'b001) : 3'b000;
      ev = (c >= 3 && c < 11) ? ((c - 3) % 2 == 1 ? 3'b010 : 3'b001) : 3'b000;
      @(negedge clk);
      total++; if (bi.ack_out !== ea) begin bad++; $display("FAIL contention_ack c=%0d got=%b want=%b", c, bi.ack_out, ea); end
      total++; if (bi.rd_valid_out !== ev) begin bad++; $display("FAIL contention_valid c=%0d got=%b want=%b", c, bi.rd_valid_out, ev); end
      if (ev == 3'b001 || ev == 3'b010) begin
        total++; if (bi.rd_data_out !== (ev == 3'b010 ? 8'hB1 : 8'hA0)) begin bad++; $display("FAIL contention_data c=%0d got=%h want=%h", c, bi.rd_data_out, ev == 3'b010 ? 8'hB1 : 8'hA0); end
      end
      tick();
    end
  endtask

  task automatic test_write_readback;
    int wr_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) lane(1, 1'b1, 1'b1, 20'h40, 8'hC3);
      if (c == 1) begin lane(1, 1'b0, 1'b0, 20'h0, 8'h0); lane(0, 1'b1, 1'b0, 20'h40, 8'h0); end
      if (c == 2) idle();
      @(negedge clk);
      if (bi.ram_wr_en_b === 1'b1) wr_cnt++;
      if (c == 0) begin
        total++; if (bi.ack_out !== 3'b010) begin bad++; $display("FAIL wr_ack got=%b want=010", bi.ack_out); end
      end
      if (c == 1) begin
        total++; if (bi.ack_out !== 3'b001) begin bad++; $display("FAIL rd_ack got=%b want=001", bi.ack_out); end
        total++; if (bi.ram_wr_en_b !== 1'b1 || bi.ram_addr_b !== 20'h40 || bi.ram_data_b !== 8'hC3) begin bad++; $display("FAIL wr_issue got=%b/%h/%h want=1/00040/c3", bi.ram_wr_en_b, bi.ram_addr_b, bi.ram_data_b); end
      end
      total++; if (bi.rd_valid_out !== (c == 4 ? 3'b001 : 3'b000)) begin bad++; $display("FAIL readback_valid c=%0d got=%b want=%b", c, bi.rd_valid_out, c == 4 ? 3'b001 : 3'b000); end
      if (c == 4) begin
        total++; if (bi.rd_data_out !== 8'hC3) begin bad++; $display("FAIL readback_data got=%h want=c3", bi.rd_data_out); end
      end
      tick();
    end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL wr_pulse_count got=%0d want=1", wr_cnt); end
  endtask

  task automatic test_fixed_prio;
    bf.req_in = 3'b111;
    for (int c = 0; c < 9; c++) begin
      logic [2:0] ea;
      if (c == 4) bf.req_in = 3'b110;
      if (c == 8) bf.req_in = 3'b111;
      ea = (c < 4 || c == 8) ? 3'b001 : (c % 2 == 1 ? 3'b100 : 3'b010);
      @(negedge clk);
      total++; if (bf.ack_out !== ea) begin bad++; $display("FAIL fixed_ack c=%0d got=%b want=%b", c, bf.ack_out, ea); end
      tick();
    end
    bf.req_in = '0;
  endtask

  task automatic test_back_to_back;
    int n = 0;
    for (int c = 0; c < 20; c++) begin
      logic [2:0] ev;
      if (c < 16) lane(2, 1'b1, 1'b0, 20'(c), 8'h0);
      else lane(2, 1'b0, 1'b0, 20'h0, 8'h0);
      ev = (c >= 3 && c < 19) ? 3'b100 : 3'b000;
      @(negedge clk);
      total++; if (bi.ack_out !== (c < 16 ? 3'b100 : 3'b000)) begin bad++; $display("FAIL b2b_ack c=%0d got=%b want=%b", c, bi.ack_out, c < 16 ? 3'b100 : 3'b000); end
      total++; if (bi.rd_valid_out !== ev) begin bad++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, bi.rd_valid_out, ev); end
      if (bi.rd_valid_out === 3'b100) begin
        total++; if (bi.rd_data_out !== 8'(n * 7 + 3)) begin bad++; $display("FAIL b2b_data n=%0d got=%h want=%h", n, bi.rd_data_out, 8'(n * 7 + 3)); end
        n++;
      end
      tick();
    end
    total++; if (n !== 16) begin bad++; $display("FAIL b2b_count got=%0d want=16", n); end
  endtask

  initial begin
    bi.req_in = '0;
    bi.wr_in = '0;
    bi.addr_in = '0;
    bi.data_in = '0;
    bf.req_in = '0;
    bf.wr_in = '0;
    bf.addr_in = '0;
    bf.data_in = '0;
    tick();
    for (int i = 0; i < 16; i++) preload(12'(i), 8'(i * 7 + 3));
    preload(12'h123, 8'h5A);
    preload(12'h010, 8'hA0);
    preload(12'h011, 8'hB1);
    preload(12'h040, 8'h00);
    test_reset();
    test_single_read();
    test_contention();
    test_write_readback();
    test_fixed_prio();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
